// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array feeder and its PE chain:
// nucleotide encoding, feeder FSM states, default score width and the
// scoring constants the PEs use.
package sw_pkg;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_Q   = 2'd1,
        ST_STREAM_R = 2'd2,
        ST_DRAIN    = 2'd3
    } state_e;

    localparam int DEF_WIDTH   = 10;

    // Linear-affine scoring shared with the PE datapath
    localparam int SC_MATCH    = 2;
    localparam int SC_MISS     = -1;
    localparam int SC_GAP_OPEN = -2;
    localparam int SC_GAP_EXT  = -1;

    function automatic int base_score(input base_e a, input base_e b);
        return (a == b) ? SC_MATCH : SC_MISS;
    endfunction

endpackage

// File: rtl/sw_base_fifo.sv
// Small elastic FIFO for reference bases. Each entry is {last, base}.
// Only instantiated by the feeder when SW_FEEDER_FIFO_EN is defined.
module sw_base_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [2:0] data_i,
    input  logic       pop_i,
    output logic [2:0] data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];

    // storage array, no reset needed: reads are gated by the occupancy count
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem_q[wr_q] <= data_i;
    end

    // pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= ptr_inc(wr_q);
            if (pop_i && !empty_o) rd_q <= ptr_inc(rd_q);
            case ({push_i && !full_o, pop_i && !empty_o})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/sw_array_feeder.sv
// Boundary feeder for a Smith-Waterman systolic chain. Loads NUM_PE query
// bases into the chain, then streams reference bases into PE[0] with a zero
// left-boundary column, drains the chain and pulses done.
// Optional build macro SW_FEEDER_FIFO_EN adds an elastic reference FIFO that
// absorbs source gaps; without it the reference stream must be gap-free.
module sw_array_feeder
    import sw_pkg::*;
#(
    parameter int NUM_PE     = 64,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err_underrun,
    input  logic             q_valid,
    input  logic [1:0]       q_data,
    output logic             q_ready,
    input  logic             r_valid,
    input  logic [1:0]       r_data,
    input  logic             r_last,
    output logic             r_ready,
    output logic [WIDTH-1:0] V_out,
    output logic [WIDTH-1:0] F_out,
    output logic [1:0]       T_out,
    output logic [1:0]       S_out,
    output logic             store_S_out,
    output logic             init_out
);
    localparam int            CW        = $clog2(NUM_PE + 2);
    localparam logic [CW-1:0] LAST_Q    = CW'(NUM_PE - 1);
    localparam logic [CW-1:0] DRAIN_END = CW'(NUM_PE + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic [1:0]    s_q, s_d, t_q, t_d;
    logic          store_q, store_d, init_q, init_d;

    // Reference source as seen by the FSM: either the port or the FIFO head
    logic       src_valid, src_last, src_take;
    logic [1:0] src_data;

`ifdef SW_FEEDER_FIFO_EN
    logic       fifo_full, fifo_empty, fifo_push;
    logic [2:0] fifo_dout;
    logic       got_last_q, got_last_d;

    // once r_last is captured the FIFO stops accepting so the next job's
    // beats never mix into this one
    assign r_ready   = ((state_q == ST_LOAD_Q) || (state_q == ST_STREAM_R)) &&
                       !fifo_full && !got_last_q;
    assign fifo_push = r_valid && r_ready;
    assign src_valid = !fifo_empty;
    assign src_data  = fifo_dout[1:0];
    assign src_last  = fifo_dout[2];
    // emission waits for a full buffer or the final beat, then runs every cycle
    assign src_take  = (state_q == ST_STREAM_R) && !fifo_empty &&
                       (seen_q || fifo_full || got_last_q);

    sw_base_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .data_i  ({r_last, r_data}),
        .pop_i   (src_take),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // remember that the final reference beat is buffered
    always_comb begin
        got_last_d = got_last_q;
        if (state_q == ST_IDLE && start) got_last_d = 1'b0;
        else if (fifo_push && r_last)    got_last_d = 1'b1;
    end

    // final-beat flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) got_last_q <= 1'b0;
        else        got_last_q <= got_last_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^FIFO_DEPTH;

    assign r_ready   = (state_q == ST_STREAM_R);
    assign src_valid = r_valid;
    assign src_data  = r_data;
    assign src_last  = r_last;
    assign src_take  = r_ready && r_valid;
`endif

    assign busy         = (state_q != ST_IDLE);
    assign q_ready      = (state_q == ST_LOAD_Q);
    assign done         = done_q;
    assign err_underrun = err_q;
    assign S_out        = s_q;
    assign store_S_out  = store_q;
    assign T_out        = t_q;
    assign init_out     = init_q;
    assign V_out        = '0;
    assign F_out        = '0;

    // next state and next PE-side outputs; outputs default to idle each cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        err_d   = err_q;
        done_d  = 1'b0;
        s_d     = 2'd0;
        store_d = 1'b0;
        t_d     = 2'd0;
        init_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_Q;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD_Q: begin
                if (q_valid) begin
                    s_d     = q_data;
                    store_d = 1'b1;
                    if (cnt_q == LAST_Q) begin
                        cnt_d   = '0;
                        state_d = ST_STREAM_R;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_STREAM_R: begin
                if (src_take) begin
                    t_d    = src_data;
                    init_d = 1'b1;
                    seen_d = 1'b1;
                    if (src_last) state_d = ST_DRAIN;
                end else if (seen_q && !src_valid) begin
                    // a hole mid-stream would corrupt the diagonal wavefront
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_END) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= 2'd0;
            store_q <= 1'b0;
            t_q     <= 2'd0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            done_q  <= done_d;
            s_q     <= s_d;
            store_q <= store_d;
            t_q     <= t_d;
            init_q  <= init_d;
        end
    end

endmodule
